bsg_axil_to_axi_hp_bridge: RTL and testbench
============================================

# bsg_axil_to_axi_hp_bridge

Converts the AXI4-Lite master stream produced by the fifo-to-AXIL master into single-beat AXI4 transactions on a Zynq HP slave port. It relocates every address by a programmable DRAM base and buffers all five channels with two-entry skid FIFOs so the HP port sees registered outputs. It bounds outstanding transactions per direction and applies correct R-channel backpressure. It sits between the AXIL master and the top-level `hp0_axi_*` pins.

## Interface
**Parameters**
- `addr_width_p`, 32, address width on both sides.
- `data_width_p`, 32, data width on both sides; must be 32 or 64.
- `id_width_p`, 6, AXI4 ID width.
- `max_outstanding_p`, 4, maximum in-flight transactions per direction (AW→B, AR→R); ≥1.

**Ports** (name, direction, width, meaning)
- `clk_i`, input, 1, the single clock.
- `reset_i`, input, 1, synchronous, active-high reset.
- `base_addr_i`, input, `addr_width_p`, DRAM base added to every address.
- `error_o`, output, 1, sticky protocol-error flag.
- `s_axil_awaddr/awprot/awvalid`, input, `addr_width_p`/3/1, AXIL write address.
- `s_axil_awready`, output, 1, AXIL write-address ready.
- `s_axil_wdata/wstrb/wvalid`, input, `data_width_p`/`data_width_p/8`/1, AXIL write data.
- `s_axil_wready`, output, 1, AXIL write-data ready.
- `s_axil_bresp/bvalid`, output, 2/1, AXIL write response.
- `s_axil_bready`, input, 1, AXIL write-response ready.
- `s_axil_araddr/arprot/arvalid`, input, `addr_width_p`/3/1, AXIL read address.
- `s_axil_arready`, output, 1, AXIL read-address ready.
- `s_axil_rdata/rresp/rvalid`, output, `data_width_p`/2/1, AXIL read data.
- `s_axil_rready`, input, 1, AXIL read-data ready.
- `m_axi_aw{addr,valid,id,lock,cache,prot,len,size,burst,qos}`, output, AXI4 widths, HP write address.
- `m_axi_awready`, input, 1, HP write-address ready.
- `m_axi_w{data,valid,id,last,strb}`, output, AXI4 widths, HP write data.
- `m_axi_wready`, input, 1, HP write-data ready.
- `m_axi_b{valid,id,resp}`, input, 1/`id_width_p`/2, HP write response.
- `m_axi_bready`, output, 1, HP write-response ready.
- `m_axi_ar*`, same set as the AW signals, HP read address.
- `m_axi_r{data,valid,id,last,resp}`, input, AXI4 widths, HP read data.
- `m_axi_rready`, output, 1, HP read-data ready.

## Operation
- **Buffering.** Each channel (AW, W, B, AR, R) passes through a two-entry FIFO.
  - Input ready = FIFO not full.
  - Output valid = FIFO not empty.
- **Address relocation.**
  - AW/AR address is computed as `s_axil_*addr + base_addr_i`, modulo 2^`addr_width_p` (carry discarded).
  - The sum is computed and stored at enqueue. A later change of `base_addr_i` affects only addresses enqueued afterwards.
- **AXI4 constant fields.**
  - `len` = 0, `size` = log2(`data_width_p`/8), `burst` = 2'b01.
  - `id` = 0, `lock` = 0, `cache` = 4'b0011, `qos` = 0.
  - `prot` is forwarded from the AXIL side.
  - `wlast` = 1, `wid` = 0.
- **Outstanding counters.** Two counters, `wr_cnt` and `rd_cnt`, each 0..`max_outstanding_p`.
  - `wr_cnt` increments on an `m_axi_aw` handshake and decrements on an `m_axi_b` handshake.
  - `rd_cnt` increments on an `m_axi_ar` handshake and decrements on an `m_axi_r` handshake.
  - Increment and decrement in the same cycle leave the count unchanged.
  - When a counter equals `max_outstanding_p`, the corresponding `m_axi_awvalid`/`m_axi_arvalid` is forced to 0 and the entry stays queued.
- **Responses.**
  - B and R responses are forwarded in order; `bresp`/`rresp` pass unchanged.
  - `m_axi_rready`/`m_axi_bready` = response FIFO not full. They are never tied to valid.
- **Error flag.** `error_o` sets on any of the following and stays set until reset. Data is still forwarded.
  - An R handshake with `rlast` = 0.
  - An R or B handshake with nonzero `rid`/`bid`.
  - A B or R handshake while the matching counter is 0 (underflow); the counter holds at 0.

## Timing
- Request latency: AXIL handshake at cycle N → HP valid at N+1 at the earliest.
- Response latency: HP response handshake at N → AXIL valid at N+1.
- Throughput is one transfer per cycle per channel when neither side stalls.
- All outputs are registered except the ready signals and the counter gating of `m_axi_awvalid`/`m_axi_arvalid`.
- Once a `valid` output is asserted, it and its payload hold until the handshake completes. The counter gate only ever blocks before the first assertion.
- Reset (any cycle, including mid-transaction):
  - All FIFOs empty, both counters 0, `error_o` = 0.
  - All `valid` outputs are 0 from the cycle after `reset_i` is sampled high.
  - Ready outputs are 1 once `reset_i` deasserts.
  - In-flight HP transactions are dropped.

## Test plan
- **Write path.** `base_addr_i`=0x1000_0000; write addr 0x40, data 0xDEADBEEF, strb 0xF.
  - Required: `m_axi_awaddr`=0x1000_0040, `awlen`=0, `awsize`=2, `awburst`=1, `wlast`=1.
  - HP `bresp`=0 → `s_axil_bvalid` with `bresp`=0 one cycle later.
- **Address wrap.** base 0xFFFF_FFF0, read addr 0x20.
  - Required: `m_axi_araddr`=0x0000_0010.
  - Change base to 0 after the enqueue; the queued address stays 0x0000_0010.
- **Outstanding limit.** `max_outstanding_p`=4; HP holds `bvalid` low; issue 6 writes.
  - Required: exactly 4 AW handshakes. The 5th AW is issued the cycle after the first B handshake.
- **R backpressure.** Issue 3 reads; HP returns 0x11, 0x22, 0x33 back-to-back; `s_axil_rready`=0 for 10 cycles.
  - Required: `m_axi_rready` drops after 2 beats, with no loss.
  - After release, `s_axil_rdata` = 0x11, 0x22, 0x33 in order.
- **Error detection.** HP returns an R beat with `rid`=3.
  - Required: `error_o`=1 next cycle and sticky; data still delivered.
  - Repeat with `rlast`=0; same response.
- **Reset mid-operation.** Assert `reset_i` with 2 reads and 2 writes in flight.
  - Required: next cycle all valids are 0, counters 0, `error_o`=0.
  - A fresh write then completes normally.

Source files
------------

// File: rtl/bsg_axil_to_axi_hp_bridge_if.sv
// Bus interfaces for the AXIL-to-HP bridge.
//
// bsg_axil_if   : AXI4-Lite bus. The master modport belongs to the side that
//                 issues requests; the slave modport belongs to the bridge.
// bsg_axi_hp_if : AXI4 bus towards a Zynq HP port. The bridge uses the master
//                 modport; the HP port (or a model of it) uses the slave modport.

interface bsg_axil_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface bsg_axi_hp_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int id_width_p   = 6
);
  logic [addr_width_p-1:0]   awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [id_width_p-1:0]     awid;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic [3:0]                awqos;
  logic [data_width_p-1:0]   wdata;
  logic                      wvalid;
  logic                      wready;
  logic [id_width_p-1:0]     wid;
  logic                      wlast;
  logic [data_width_p/8-1:0] wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [id_width_p-1:0]     bid;
  logic [1:0]                bresp;
  logic [addr_width_p-1:0]   araddr;
  logic                      arvalid;
  logic                      arready;
  logic [id_width_p-1:0]     arid;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic [3:0]                arqos;
  logic [data_width_p-1:0]   rdata;
  logic                      rvalid;
  logic                      rready;
  logic [id_width_p-1:0]     rid;
  logic                      rlast;
  logic [1:0]                rresp;

  modport master (
    output awaddr, awvalid, awid, awlock, awcache, awprot, awlen, awsize, awburst, awqos,
           wdata, wvalid, wid, wlast, wstrb, bready,
           araddr, arvalid, arid, arlock, arcache, arprot, arlen, arsize, arburst, arqos,
           rready,
    input  awready, wready, bvalid, bid, bresp, arready, rdata, rvalid, rid, rlast, rresp
  );

  modport slave (
    input  awaddr, awvalid, awid, awlock, awcache, awprot, awlen, awsize, awburst, awqos,
           wdata, wvalid, wid, wlast, wstrb, bready,
           araddr, arvalid, arid, arlock, arcache, arprot, arlen, arsize, arburst, arqos,
           rready,
    output awready, wready, bvalid, bid, bresp, arready, rdata, rvalid, rid, rlast, rresp
  );
endinterface

// File: rtl/bsg_axil_to_axi_hp_bridge.sv
// AXI4-Lite to AXI4 HP bridge.
//
// Turns each AXIL request into a single-beat AXI4 transaction on a Zynq HP
// port, adding a DRAM base to every address. All five channels go through
// two-entry FIFOs whose head register drives the outgoing payload directly.
// In-flight transactions are bounded per direction, and error_o latches any
// malformed or unexpected HP response.
//
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   base_addr_i    : DRAM base added to AW/AR addresses when they are enqueued
//   error_o        : sticky protocol-error flag
//   s_axil         : AXIL slave side (requests in, responses out)
//   m_axi          : AXI4 master side towards the HP port

// Two-entry FIFO. head_r is the output register, and tail_r holds the second
// entry, so data_o and v_o come straight from flops.
module bsg_axil_to_axi_hp_fifo2 #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  logic [1:0]         count_r;
  logic [width_p-1:0] head_r;
  logic [width_p-1:0] tail_r;
  logic               enq;
  logic               deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = head_r;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // An enqueue together with a dequeue is only possible when the FIFO is not
  // full, so with one entry the new word goes straight into head.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= 2'd0;
    end else if (enq && !deq) begin
      if (count_r == 2'd0) head_r <= data_i;
      else                 tail_r <= data_i;
      count_r <= count_r + 2'd1;
    end else if (!enq && deq) begin
      head_r  <= tail_r;
      count_r <= count_r - 2'd1;
    end else if (enq && deq) begin
      head_r <= data_i;
    end
  end
endmodule

module bsg_axil_to_axi_hp_bridge #(
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int id_width_p        = 6,
  parameter int max_outstanding_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] base_addr_i,
  output logic                    error_o,
  bsg_axil_if.slave               s_axil,
  bsg_axi_hp_if.master            m_axi
);
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);
  localparam logic [2:0] size_lp = (data_width_p == 64) ? 3'd3 : 3'd2;

  logic [cnt_width_lp-1:0] wr_cnt_r, rd_cnt_r;
  logic                    error_r;
  logic                    aw_v, ar_v;
  logic                    aw_hs, b_hs, ar_hs, r_hs;
  logic                    wr_err, rd_err;
  logic [addr_width_p-1:0] aw_reloc, ar_reloc;

  // Relocation happens at enqueue, so a queued address is unaffected by a
  // later base change.
  assign aw_reloc = s_axil.awaddr + base_addr_i;
  assign ar_reloc = s_axil.araddr + base_addr_i;

  bsg_axil_to_axi_hp_fifo2 #(.width_p(addr_width_p + 3)) aw_fifo (
    .clk_i, .reset_i,
    .data_i ({aw_reloc, s_axil.awprot}), .v_i(s_axil.awvalid), .ready_o(s_axil.awready),
    .data_o ({m_axi.awaddr, m_axi.awprot}), .v_o(aw_v), .yumi_i(aw_hs)
  );

  bsg_axil_to_axi_hp_fifo2 #(.width_p(data_width_p + data_width_p/8)) w_fifo (
    .clk_i, .reset_i,
    .data_i ({s_axil.wdata, s_axil.wstrb}), .v_i(s_axil.wvalid), .ready_o(s_axil.wready),
    .data_o ({m_axi.wdata, m_axi.wstrb}), .v_o(m_axi.wvalid),
    .yumi_i (m_axi.wvalid & m_axi.wready)
  );

  bsg_axil_to_axi_hp_fifo2 #(.width_p(2)) b_fifo (
    .clk_i, .reset_i,
    .data_i (m_axi.bresp), .v_i(m_axi.bvalid), .ready_o(m_axi.bready),
    .data_o (s_axil.bresp), .v_o(s_axil.bvalid),
    .yumi_i (s_axil.bvalid & s_axil.bready)
  );

  bsg_axil_to_axi_hp_fifo2 #(.width_p(addr_width_p + 3)) ar_fifo (
    .clk_i, .reset_i,
    .data_i ({ar_reloc, s_axil.arprot}), .v_i(s_axil.arvalid), .ready_o(s_axil.arready),
    .data_o ({m_axi.araddr, m_axi.arprot}), .v_o(ar_v), .yumi_i(ar_hs)
  );

  bsg_axil_to_axi_hp_fifo2 #(.width_p(data_width_p + 2)) r_fifo (
    .clk_i, .reset_i,
    .data_i ({m_axi.rdata, m_axi.rresp}), .v_i(m_axi.rvalid), .ready_o(m_axi.rready),
    .data_o ({s_axil.rdata, s_axil.rresp}), .v_o(s_axil.rvalid),
    .yumi_i (s_axil.rvalid & s_axil.rready)
  );

  // Gating by the counter cannot drop an asserted valid: while a request is
  // offered, only its own handshake can raise the count.
  assign m_axi.awvalid = aw_v & (wr_cnt_r != max_cnt_lp);
  assign m_axi.arvalid = ar_v & (rd_cnt_r != max_cnt_lp);

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign ar_hs = m_axi.arvalid & m_axi.arready;
  assign b_hs  = m_axi.bvalid  & m_axi.bready;
  assign r_hs  = m_axi.rvalid  & m_axi.rready;

  assign m_axi.awid    = '0;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = size_lp;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.wid     = '0;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.arid    = '0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = size_lp;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arqos   = 4'd0;

  // A response is bad if it carries a nonzero id, is not a last beat, or
  // arrives with nothing outstanding.
  assign wr_err = b_hs & ((m_axi.bid != '0) | (wr_cnt_r == '0));
  assign rd_err = r_hs & ((m_axi.rid != '0) | ~m_axi.rlast | (rd_cnt_r == '0));

  // Outstanding counters and the sticky error flag. An unexpected response
  // leaves a zero counter at zero instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_cnt_r <= '0;
      rd_cnt_r <= '0;
      error_r  <= 1'b0;
    end else begin
      if (aw_hs && !b_hs)                            wr_cnt_r <= wr_cnt_r + 1'b1;
      else if (!aw_hs && b_hs && wr_cnt_r != '0)     wr_cnt_r <= wr_cnt_r - 1'b1;
      if (ar_hs && !r_hs)                            rd_cnt_r <= rd_cnt_r + 1'b1;
      else if (!ar_hs && r_hs && rd_cnt_r != '0)     rd_cnt_r <= rd_cnt_r - 1'b1;
      if (wr_err || rd_err)                          error_r  <= 1'b1;
    end
  end

  assign error_o = error_r;
endmodule

// File: tb/tb_bsg_axil_to_axi_hp_bridge.sv
// Directed self-checking bench for bsg_axil_to_axi_hp_bridge. The bench plays
// the AXIL master on one side and the HP slave on the other.
module tb_bsg_axil_to_axi_hp_bridge;
  logic        clk;
  logic        reset_i;
  logic [31:0] base_addr_i;
  logic        error_o;
  int          total_checks;
  int          bad_checks;

  bsg_axil_if   #(.addr_width_p(32), .data_width_p(32)) axil ();
  bsg_axi_hp_if #(.addr_width_p(32), .data_width_p(32), .id_width_p(6)) hp ();

  bsg_axil_to_axi_hp_bridge #(
    .addr_width_p(32), .data_width_p(32), .id_width_p(6), .max_outstanding_p(4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .base_addr_i (base_addr_i),
    .error_o     (error_o),
    .s_axil      (axil),
    .m_axi       (hp)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a stimulus loop ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, actual, expected);
    end
  endtask

  // Push one AXIL write (AW and W together) or read (AR) into the bridge,
  // holding each valid until its handshake lands.
  task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data);
    bit aw_go, w_go, ar_go;
    int guard;
    if (is_write) begin
      axil.awaddr = addr; axil.awprot = 3'd0; axil.awvalid = 1'b1;
      axil.wdata = data; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    end else begin
      axil.araddr = addr; axil.arprot = 3'd0; axil.arvalid = 1'b1;
    end
    guard = 0;
    while ((axil.awvalid || axil.wvalid || axil.arvalid) && guard < 10) begin
      aw_go = axil.awvalid && axil.awready;
      w_go  = axil.wvalid && axil.wready;
      ar_go = axil.arvalid && axil.arready;
      tick();
      if (aw_go) axil.awvalid = 1'b0;
      if (w_go)  axil.wvalid  = 1'b0;
      if (ar_go) axil.arvalid = 1'b0;
      guard++;
    end
    checkOutput("stim_accept", 64'(guard < 10), 64'd1);
  endtask

  task automatic applyReset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int aw_sent, w_sent, ar_sent, aw_hs, ar_hs, b_sent, sb_hs, k, j;
    logic [31:0] rvals [3];
    rvals[0] = 32'h11; rvals[1] = 32'h22; rvals[2] = 32'h33;
    total_checks = 0;
    bad_checks   = 0;

    reset_i = 1'b1;
    base_addr_i = 32'h1000_0000;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b1;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b1;
    hp.awready = 1'b0; hp.wready = 1'b0; hp.arready = 1'b0;
    hp.bvalid = 1'b0; hp.bid = '0; hp.bresp = '0;
    hp.rvalid = 1'b0; hp.rid = '0; hp.rlast = 1'b1; hp.rresp = '0; hp.rdata = '0;
    tick(); tick();
    reset_i = 1'b0;

    // Reset state.
    checkOutput("rst_awvalid", 64'(hp.awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(hp.wvalid), 64'd0);
    checkOutput("rst_arvalid", 64'(hp.arvalid), 64'd0);
    checkOutput("rst_bvalid", 64'(axil.bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(axil.rvalid), 64'd0);
    checkOutput("rst_error", 64'(error_o), 64'd0);
    checkOutput("rst_awready", 64'(axil.awready), 64'd1);
    checkOutput("rst_arready", 64'(axil.arready), 64'd1);
    checkOutput("rst_bready", 64'(hp.bready), 64'd1);

    // Write path: relocated address and fixed AXI4 fields.
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF);
    checkOutput("wr_awvalid", 64'(hp.awvalid), 64'd1);
    checkOutput("wr_awaddr", 64'(hp.awaddr), 64'h1000_0040);
    checkOutput("wr_awlen", 64'(hp.awlen), 64'd0);
    checkOutput("wr_awsize", 64'(hp.awsize), 64'd2);
    checkOutput("wr_awburst", 64'(hp.awburst), 64'd1);
    checkOutput("wr_awcache", 64'(hp.awcache), 64'd3);
    checkOutput("wr_wvalid", 64'(hp.wvalid), 64'd1);
    checkOutput("wr_wdata", 64'(hp.wdata), 64'hDEADBEEF);
    checkOutput("wr_wstrb", 64'(hp.wstrb), 64'hF);
    checkOutput("wr_wlast", 64'(hp.wlast), 64'd1);
    hp.awready = 1'b1; hp.wready = 1'b1;
    tick();
    checkOutput("wr_aw_done", 64'(hp.awvalid), 64'd0);
    checkOutput("wr_w_done", 64'(hp.wvalid), 64'd0);
    hp.bvalid = 1'b1; hp.bresp = 2'd0;
    tick();
    hp.bvalid = 1'b0;
    checkOutput("wr_bvalid", 64'(axil.bvalid), 64'd1);
    checkOutput("wr_bresp", 64'(axil.bresp), 64'd0);
    tick();
    checkOutput("wr_b_done", 64'(axil.bvalid), 64'd0);

    // Address wrap; a base change after enqueue must not alter the entry.
    base_addr_i = 32'hFFFF_FFF0;
    applyStimulus(1'b0, 32'h20, 32'h0);
    base_addr_i = 32'h0;
    tick();
    checkOutput("wrap_arvalid", 64'(hp.arvalid), 64'd1);
    checkOutput("wrap_araddr", 64'(hp.araddr), 64'h0000_0010);
    hp.arready = 1'b1;
    tick();
    hp.rvalid = 1'b1; hp.rdata = 32'hABCD; hp.rlast = 1'b1; hp.rid = '0;
    tick();
    hp.rvalid = 1'b0;
    checkOutput("wrap_rvalid", 64'(axil.rvalid), 64'd1);
    checkOutput("wrap_rdata", 64'(axil.rdata), 64'hABCD);
    tick();

    // Outstanding limit: six writes while the HP port holds back B.
    base_addr_i = 32'h1000_0000;
    aw_sent = 0; w_sent = 0; aw_hs = 0;
    for (int c = 0; c < 20; c++) begin
      axil.awvalid = (aw_sent < 6); axil.awaddr = 32'(aw_sent * 4);
      axil.wvalid  = (w_sent < 6);  axil.wdata  = 32'(w_sent);
      if (axil.awvalid && axil.awready) aw_sent++;
      if (axil.wvalid && axil.wready) w_sent++;
      if (hp.awvalid && hp.awready) aw_hs++;
      tick();
    end
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    checkOutput("lim_aw_count", 64'(aw_hs), 64'd4);
    checkOutput("lim_awvalid_gated", 64'(hp.awvalid), 64'd0);
    hp.bvalid = 1'b1;
    tick();
    b_sent = 1;
    checkOutput("lim_aw5_after_b", 64'(hp.awvalid), 64'd1);
    sb_hs = 0;
    for (int c = 0; c < 20; c++) begin
      hp.bvalid = (b_sent < 6);
      if (hp.bvalid && hp.bready) b_sent++;
      if (hp.awvalid && hp.awready) aw_hs++;
      if (axil.bvalid && axil.bready) sb_hs++;
      tick();
    end
    hp.bvalid = 1'b0;
    checkOutput("lim_aw_total", 64'(aw_hs), 64'd6);
    checkOutput("lim_axil_b_total", 64'(sb_hs), 64'd6);
    checkOutput("lim_error", 64'(error_o), 64'd0);

    // R backpressure: three beats back-to-back while AXIL rready is low.
    ar_sent = 0; ar_hs = 0;
    for (int c = 0; c < 10; c++) begin
      axil.arvalid = (ar_sent < 3); axil.araddr = 32'h200;
      if (axil.arvalid && axil.arready) ar_sent++;
      if (hp.arvalid && hp.arready) ar_hs++;
      tick();
    end
    axil.arvalid = 1'b0;
    checkOutput("bp_ar_count", 64'(ar_hs), 64'd3);
    axil.rready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      hp.rvalid = (k < 3); hp.rlast = 1'b1; hp.rid = '0;
      hp.rdata = (k < 3) ? rvals[k] : 32'h0;
      if (hp.rvalid && hp.rready) k++;
      tick();
    end
    checkOutput("bp_beats_taken", 64'(k), 64'd2);
    checkOutput("bp_rready_low", 64'(hp.rready), 64'd0);
    axil.rready = 1'b1;
    j = 0;
    for (int c = 0; c < 20; c++) begin
      hp.rvalid = (k < 3);
      hp.rdata = (k < 3) ? rvals[k] : 32'h0;
      if (hp.rvalid && hp.rready) k++;
      if (axil.rvalid && axil.rready) begin
        checkOutput("bp_rdata_order", 64'(axil.rdata), 64'(rvals[j < 3 ? j : 2]));
        j++;
      end
      tick();
    end
    hp.rvalid = 1'b0;
    checkOutput("bp_beats_out", 64'(j), 64'd3);
    checkOutput("bp_error", 64'(error_o), 64'd0);

    // Error on nonzero rid; data still delivered, flag sticky.
    applyStimulus(1'b0, 32'h100, 32'h0);
    tick(); tick();
    hp.rvalid = 1'b1; hp.rid = 6'd3; hp.rlast = 1'b1; hp.rdata = 32'h55;
    tick();
    hp.rvalid = 1'b0; hp.rid = '0;
    checkOutput("err_rid_flag", 64'(error_o), 64'd1);
    checkOutput("err_rid_rvalid", 64'(axil.rvalid), 64'd1);
    checkOutput("err_rid_rdata", 64'(axil.rdata), 64'h55);
    tick(); tick(); tick();
    checkOutput("err_sticky", 64'(error_o), 64'd1);
    applyReset();
    checkOutput("err_cleared", 64'(error_o), 64'd0);

    // Error on rlast = 0.
    applyStimulus(1'b0, 32'h104, 32'h0);
    tick(); tick();
    hp.rvalid = 1'b1; hp.rlast = 1'b0; hp.rdata = 32'h66;
    tick();
    hp.rvalid = 1'b0; hp.rlast = 1'b1;
    checkOutput("err_rlast_flag", 64'(error_o), 64'd1);
    checkOutput("err_rlast_rdata", 64'(axil.rdata), 64'h66);
    tick();
    applyReset();

    // Reset with two reads and two writes in flight plus queued work.
    applyStimulus(1'b1, 32'h0, 32'h1);
    applyStimulus(1'b1, 32'h4, 32'h2);
    applyStimulus(1'b0, 32'h8, 32'h0);
    applyStimulus(1'b0, 32'hC, 32'h0);
    tick(); tick(); tick();
    hp.awready = 1'b0;
    axil.rready = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'h3);
    hp.rvalid = 1'b1; hp.rdata = 32'h77;
    tick();
    hp.rvalid = 1'b0;
    checkOutput("mid_awvalid_pre", 64'(hp.awvalid), 64'd1);
    checkOutput("mid_rvalid_pre", 64'(axil.rvalid), 64'd1);
    reset_i = 1'b1;
    tick();
    checkOutput("mid_awvalid", 64'(hp.awvalid), 64'd0);
    checkOutput("mid_wvalid", 64'(hp.wvalid), 64'd0);
    checkOutput("mid_arvalid", 64'(hp.arvalid), 64'd0);
    checkOutput("mid_rvalid", 64'(axil.rvalid), 64'd0);
    checkOutput("mid_bvalid", 64'(axil.bvalid), 64'd0);
    checkOutput("mid_error", 64'(error_o), 64'd0);
    reset_i = 1'b0;
    axil.rready = 1'b1;
    hp.awready = 1'b1;
    checkOutput("mid_awready", 64'(axil.awready), 64'd1);

    // Fresh write after reset completes normally.
    applyStimulus(1'b1, 32'h80, 32'h12345678);
    checkOutput("fresh_awaddr", 64'(hp.awaddr), 64'h1000_0080);
    checkOutput("fresh_wdata", 64'(hp.wdata), 64'h12345678);
    tick();
    hp.bvalid = 1'b1; hp.bresp = 2'd0;
    tick();
    hp.bvalid = 1'b0;
    checkOutput("fresh_bvalid", 64'(axil.bvalid), 64'd1);
    checkOutput("fresh_bresp", 64'(axil.bresp), 64'd0);
    checkOutput("fresh_error", 64'(error_o), 64'd0);
    tick();

    // The write counter is back at zero, so one more B is an underflow; its
    // response code is still forwarded.
    hp.bvalid = 1'b1; hp.bresp = 2'b10;
    tick();
    hp.bvalid = 1'b0;
    checkOutput("underflow_error", 64'(error_o), 64'd1);
    checkOutput("underflow_bresp", 64'(axil.bresp), 64'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end
endmodule
